// File: rtl/bf_pkg.sv
// Shared types and constants for the memory address-path arbiter.
// It covers requester indices, the FSM state encoding and a one-hot helper.
package bf_pkg;

  localparam int ADDR_W = 13;

  localparam logic [1:0] REQ_PC  = 2'd0;
  localparam logic [1:0] REQ_DP  = 2'd1;
  localparam logic [1:0] REQ_STK = 2'd2;
  localparam logic [1:0] REQ_DBG = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bf_mem_arbiter_if.sv
// Bundle of the requester handshake and memory strobe signals around the arbiter.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface bf_mem_arbiter_if;

  logic [3:0] req;
  logic [3:0] we_in;
  logic       lock;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [1:0] sel;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ready;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  modport master (
    input  req, we_in, lock, mem_ready, err_clr,
    output gnt, done, sel, mem_req, mem_we, busy, timeout_err
  );

  modport slave (
    output req, we_in, lock, mem_ready, err_clr,
    input  gnt, done, sel, mem_req, mem_we, busy, timeout_err
  );

endinterface

// File: rtl/bf_rr_pick4.sv
// Combinational round-robin picker: the first set request bit found scanning
// from ptr upward (mod 4) wins.
module bf_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester ptr.
    rot = 4'({req, req} >> ptr);
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    winner = ptr + off;
    any    = |req;
  end

endmodule

// File: rtl/bf_mem_arbiter.sv
// Four-way round-robin arbiter for the shared memory address path. It holds the
// mux select through a setup window and the access, with an optional debug-port lock.
module bf_mem_arbiter
  import bf_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 200,
  parameter int TMO_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bf_mem_arbiter_if.master bus
);

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [2:0]       setup_q, setup_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic [1:0]       winner;
  logic             any_req;

  bf_rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'd0;
      we_q    <= 1'b0;
      setup_q <= 3'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      setup_q <= setup_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    setup_d = setup_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    // A timeout detected below overrides a same-cycle clear.
    if (bus.err_clr) err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          gnt_d   = onehot4(winner);
          we_d    = bus.we_in[winner];
          setup_d = 3'd0;
          tmo_d   = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (setup_q == 3'(SETUP_CYCLES - 1)) begin
          setup_d = 3'd0;
          state_d = ST_ACCESS;
        end else begin
          setup_d = setup_q + 3'd1;
        end
      end

      ST_ACCESS: begin
        if (bus.mem_ready) begin
          state_d = ST_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_DONE: begin
        // A locked debug port keeps the pointer on itself so it wins again.
        if (sel_q == REQ_DBG && bus.lock) ptr_d = REQ_DBG;
        else                             ptr_d = sel_q + 2'd1;
        gnt_d   = 4'd0;
        setup_d = 3'd0;
        tmo_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.gnt         = gnt_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_req     = (state_q == ST_ACCESS);
  assign bus.done        = (state_q == ST_DONE) ? gnt_q : 4'd0;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Directed bench for bf_mem_arbiter: inputs driven and outputs checked on the
// falling edge, with expected values worked out by hand from the cycle timing.
module tb_bf_mem_arbiter;

  localparam int TMO = 12;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bf_mem_arbiter_if bus ();

  bf_mem_arbiter #(.SETUP_CYCLES(1), .TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset_init();
    tick(); tick();
    checks++; if (bus.gnt !== 4'd0) begin errors++; $display("FAIL rst_gnt: got %b expected %b", bus.gnt, 4'd0); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d expected 0", bus.sel); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 4'd0) begin errors++; $display("FAIL rst_done: got %b expected 0000", bus.done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.timeout_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_w [6];
    logic [3:0] exp_oh;
    exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.req = 4'b1111;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_oh = 4'b0001 << exp_w[k];
      tick();
      checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_oh); end
      checks++; if (bus.sel !== exp_w[k]) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, bus.sel, exp_w[k]); end
      tick();
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rr_mem_req[%0d]: got %b expected 1", k, bus.mem_req); end
      tick();
      checks++; if (bus.done !== exp_oh) begin errors++; $display("FAIL rr_done[%0d]: got %b expected %b", k, bus.done, exp_oh); end
      if (k == 5) begin bus.req = 4'b0000; bus.mem_ready = 1'b0; end
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'd0) begin errors++; $display("FAIL rr_idle[%0d]: got busy=%b gnt=%b expected busy=0 gnt=0000", k, bus.busy, bus.gnt); end
    end
  endtask

  task automatic test_single();
    bus.req = 4'b0010;
    bus.we_in = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt_setup: got %b expected 0010", bus.gnt); end
    checks++; if (bus.sel !== 2'd1) begin errors++; $display("FAIL single_sel: got %0d expected 1", bus.sel); end
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL single_mem_we: got %b expected 1", bus.mem_we); end
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_setup: got mem_req=%b busy=%b expected 0 1", bus.mem_req, bus.busy); end
    bus.we_in = 4'b0000;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_access1: got mem_req=%b gnt=%b expected 1 0010", bus.mem_req, bus.gnt); end
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL single_we_hold: got %b expected 1", bus.mem_we); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.done !== 4'd0 || bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_access2: got mem_req=%b done=%b gnt=%b expected 1 0000 0010", bus.mem_req, bus.done, bus.gnt); end
    bus.mem_ready = 1'b1;
    tick();
    checks++; if (bus.done !== 4'b0010 || bus.mem_req !== 1'b0 || bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_done: got done=%b mem_req=%b gnt=%b expected 0010 0 0010", bus.done, bus.mem_req, bus.gnt); end
    bus.mem_ready = 1'b0;
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.done !== 4'd0 || bus.gnt !== 4'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b gnt=%b busy=%b expected 0000 0000 0", bus.done, bus.gnt, bus.busy); end
    checks++; if (bus.sel !== 2'd1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL single_hold: got sel=%0d mem_we=%b expected 1 1", bus.sel, bus.mem_we); end
  endtask

  task automatic test_timeout();
    int cnt;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL tmo_gnt: got %b expected 0100", bus.gnt); end
    tick();
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    checks++; if (cnt !== TMO) begin errors++; $display("FAIL tmo_len: got %0d cycles expected %0d", cnt, TMO); end
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL tmo_done: got %b expected 0100", bus.done); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", bus.timeout_err); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_sticky: got err=%b busy=%b expected 1 0", bus.timeout_err, bus.busy); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clr: got %b expected 0", bus.timeout_err); end
    bus.req = 4'b0100;
    tick();
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_last_cycle: got mem_req=%b err=%b expected 1 0", bus.mem_req, bus.timeout_err); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++; if (bus.timeout_err !== 1'b1 || bus.done !== 4'b0100) begin errors++; $display("FAIL tmo_set_wins: got err=%b done=%b expected 1 0100", bus.timeout_err, bus.done); end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_lock();
    logic [3:0] exp_oh;
    bus.req = 4'b1001;
    bus.lock = 1'b1;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k < 3) ? 4'b1000 : 4'b0001;
      tick();
      checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_oh); end
      tick();
      tick();
      checks++; if (bus.done !== exp_oh) begin errors++; $display("FAIL lock_done[%0d]: got %b expected %b", k, bus.done, exp_oh); end
      if (k == 2) bus.lock = 1'b0;
      if (k == 3) begin bus.req = 4'b0000; bus.mem_ready = 1'b0; end
      tick();
    end
  endtask

  task automatic test_stray_ready();
    bus.req = 4'b0010;
    bus.mem_ready = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL stray_gnt: got %b expected 0010", bus.gnt); end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL stray_mem_req: got %b expected 1", bus.mem_req); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.done !== 4'd0) begin errors++; $display("FAIL stray_ignored: got mem_req=%b done=%b expected 1 0000", bus.mem_req, bus.done); end
    bus.mem_ready = 1'b1;
    tick();
    checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL stray_done: got %b expected 0010", bus.done); end
    bus.mem_ready = 1'b0;
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bus.req = 4'b1111;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL rstmid_pre_gnt: got %b expected 0100", bus.gnt); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got mem_req=%b err=%b expected 1 1", bus.mem_req, bus.timeout_err); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.gnt !== 4'd0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_async: got mem_req=%b gnt=%b busy=%b err=%b expected 0 0000 0 0", bus.mem_req, bus.gnt, bus.busy, bus.timeout_err); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin errors++; $display("FAIL rstmid_first_gnt: got gnt=%b sel=%0d expected 0001 0", bus.gnt, bus.sel); end
    bus.req = 4'b0000;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL rstmid_drop_req_done: got %b expected 0001", bus.done); end
    bus.mem_ready = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b expected 0", bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.we_in = 4'b0000;
    bus.lock = 1'b0;
    bus.mem_ready = 1'b0;
    bus.err_clr = 1'b0;
    test_reset_init();
    test_round_robin();
    test_single();
    test_timeout();
    test_lock();
    test_stray_ready();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_mem_arbiter.md
Name: bf_mem_arbiter

Overview:
Sequences the shared 13-bit memory address path between four requesters:
- 0 = program counter fetch
- 1 = data pointer read/write
- 2 = loop-stack access
- 3 = debug/loader port

It drives the 2-bit select of the 4:1 address mux and a single memory strobe. It holds the selection stable for a setup window and for the whole access, and returns a one-cycle completion pulse to the winner. Arbitration is round-robin, with a lock option for the debug port during program loading.

Parameters:
- SETUP_CYCLES, 1, cycles the select is held before mem_req rises (address settle through mux); legal 1..7
- TIMEOUT, 200, max cycles in ACCESS waiting for mem_ready before abort; legal 1..255
- TMO_W, 8, width of timeout counter; must satisfy TIMEOUT < 2**TMO_W

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  4  per-requester access request, level, held until its done pulse
- we_in  in  4  per-requester write enable, sampled with req at grant
- lock  in  1  when high, requester 3 keeps the bus across back-to-back accesses
- gnt  out  4  one-hot grant, high from SETUP entry through DONE
- done  out  4  one-cycle completion pulse to the granted requester
- sel  out  2  select to the address/data mux, index of current winner
- mem_req  out  1  memory strobe, high only in ACCESS
- mem_we  out  1  write qualifier, stable with sel
- mem_ready  in  1  memory completion, sampled only in ACCESS
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky abort flag
- err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sel=0, gnt=0, done=0, mem_req=0, mem_we=0, busy=0, timeout_err=0.
  - Internal: FSM=IDLE, rr pointer=0, setup counter=0, timeout counter=0.
  - mem_req drops immediately, even mid-access.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If req!=0, pick the winner as the first set bit scanning ptr, ptr+1, ... mod 4.
  - Register sel=winner, gnt=onehot(winner), mem_we=we_in[winner]; enter SETUP.
  - If req=0, stay in IDLE.
- SETUP:
  - mem_req=0; counter runs SETUP_CYCLES cycles, then go to ACCESS.
  - mem_ready is ignored in this state.
- ACCESS:
  - mem_req=1; timeout counter increments each cycle.
  - mem_ready=1 sampled: go to DONE.
  - Counter reaches TIMEOUT with no ready: set timeout_err, go to DONE. The abort still completes the handshake.
- DONE (exactly one cycle):
  - mem_req=0; done[winner]=1; gnt, sel and mem_we still held.
  - Update ptr=winner+1 mod 4, clear counters, go to IDLE.
- Lock:
  - On DONE with winner=3 and lock=1, ptr is set to 3 instead of 4 mod 4. Requester 3 then wins every IDLE in which req[3]=1, regardless of other requests.
  - lock=1 with req[3]=0: normal round-robin.
- Stability: sel, gnt and mem_we change only on IDLE->SETUP, and clear on DONE->IDLE (gnt->0; sel and mem_we hold their last value).
- Latency: req high at edge N (IDLE), with mem_ready returned in the first ACCESS cycle:
  - gnt/sel valid after edge N+1
  - mem_req high after edge N+1+SETUP_CYCLES
  - done high in the cycle after mem_ready is sampled
  - With SETUP_CYCLES=1: done at edge N+4; minimum repeat period 4 cycles.
- Protocol violations:
  - A requester dropping req mid-access does not abort; the access completes and done still pulses.
  - A change on we_in after grant is ignored.
- err_clr and a new timeout in the same cycle: set wins.
- done and gnt are never multi-hot; mem_req is never high outside ACCESS.

Decomposition:
- Package bf_pkg:
  - ADDR_W=13
  - requester indices REQ_PC=0, REQ_DP=1, REQ_STK=2, REQ_DBG=3
  - arbiter state encoding (IDLE=0, SETUP=1, ACCESS=2, DONE=3)
- Sub-module bf_rr_pick4: combinational round-robin picker. Inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any.
- The FSM, counters and lock logic stay in bf_mem_arbiter.

Test Plan:
1. Reset: assert rst_n=0 mid-ACCESS -> mem_req, gnt, busy, timeout_err go 0 immediately; after release, first grant with all req=1 is requester 0.
2. Single request: req=4'b0010, we_in[1]=1, mem_ready one cycle after mem_req rises -> sel=1, mem_we=1, gnt=4'b0010 for 4 cycles, single done=4'b0010 pulse, busy back to 0.
3. Round-robin fairness: req=4'b1111 held, mem_ready immediate -> grant order 0,1,2,3,0,1, each access exactly 4 cycles apart.
4. Timeout: req[2]=1, mem_ready never asserted -> mem_req high exactly TIMEOUT cycles, then done[2] pulse and timeout_err=1 sticky. err_clr pulse -> 0. err_clr coincident with a second timeout -> stays 1.
5. Lock: req=4'b1001, first grant reaches 3, lock=1 -> requester 3 granted 3 consecutive times. lock=0 -> next grant goes to 0.
6. Stray mem_ready: mem_ready pulsed during SETUP only -> ignored, mem_req still asserts; done follows only the ACCESS-phase ready.
